// File: rtl/lfsr_packer_if.sv
// ----------------------------------------------------------------------------
// lfsr_packer_if
// Word output port of lfsr_packer.
//
// Handshake: the master holds word_valid high while it has a word and shows
// that word on word_data. A word moves on every rising edge where word_valid
// and word_ready are both high. word_ready has no effect while word_valid is
// low. word_data is only meaningful while word_valid is high.
//
// Signals:
//   word_valid  master -> slave   head word available
//   word_ready  slave  -> master  head word accepted this cycle
//   word_data   master -> slave   head word, WIDTH bits
// ----------------------------------------------------------------------------
interface lfsr_packer_if #(
    parameter int WIDTH = 8
);
    logic             word_valid;
    logic             word_ready;
    logic [WIDTH-1:0] word_data;

    modport master (
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        output word_ready
    );
endinterface

// File: rtl/lfsr_packer.sv
// ----------------------------------------------------------------------------
// lfsr_packer
// Requests bits from an lfsr block, packs them LSB-first into WIDTH-bit words
// and queues the words in a DEPTH-entry show-ahead FIFO. The first bit of a
// word is requested only when a FIFO slot is reserved for that word, so a
// push never meets a full FIFO and no bit is lost or duplicated.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset, shared with the lfsr
//   run       in   permission to request new bits
//   lfsr_en   out  registered shift request to the lfsr
//   lfsr_bit  in   registered rand_bit from the lfsr
//   word      if   master side of the word valid/ready port
//   level     out  FIFO occupancy
// ----------------------------------------------------------------------------
module lfsr_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    output logic                       lfsr_en,
    input  logic                       lfsr_bit,
    lfsr_packer_if.master              word,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int RW = LW + 1;

    logic             bit_pend;
    logic [CW-1:0]    req_cnt;
    logic [CW-1:0]    req_cnt_nxt;
    logic [CW-1:0]    cap_cnt;
    logic [WIDTH-2:0] partial;
    logic [1:0]       inflight;
    logic [1:0]       inflight_nxt;
    logic [LW-1:0]    level_nxt;
    logic [RW-1:0]    reserved_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             first_req;
    logic             en_nxt;

    // The WIDTH-th capture completes a word and pushes it in the same cycle.
    assign push      = bit_pend && (cap_cnt == CW'(WIDTH - 1));
    assign pop       = word.word_valid && word.word_ready;
    assign first_req = lfsr_en && (req_cnt == '0);

    // The credit decision looks at the state after this edge: a request in
    // the next cycle that starts a new word must see the slot count that
    // includes every word already started.
    always_comb begin
        req_cnt_nxt = req_cnt;
        if (lfsr_en) begin
            req_cnt_nxt = (req_cnt == CW'(WIDTH - 1)) ? '0 : req_cnt + CW'(1);
        end
        inflight_nxt = inflight + 2'(first_req) - 2'(push);
        level_nxt    = level + LW'(push) - LW'(pop);
        reserved_nxt = RW'(level_nxt) + RW'(inflight_nxt);
        en_nxt       = run && ((req_cnt_nxt != '0) || (reserved_nxt < RW'(DEPTH)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_en  <= 1'b0;
            bit_pend <= 1'b0;
            req_cnt  <= '0;
            cap_cnt  <= '0;
            partial  <= '0;
            inflight <= '0;
            level    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            lfsr_en  <= en_nxt;
            bit_pend <= lfsr_en;
            req_cnt  <= req_cnt_nxt;
            inflight <= inflight_nxt;
            level    <= level_nxt;
            if (bit_pend) begin
                if (cap_cnt == CW'(WIDTH - 1)) begin
                    cap_cnt <= '0;
                end else begin
                    cap_cnt <= cap_cnt + CW'(1);
                    for (int i = 0; i < WIDTH - 1; i++) begin
                        if (cap_cnt == CW'(i)) begin
                            partial[i] <= lfsr_bit;
                        end
                    end
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Storage is cleared on reset so word_data reads 0 until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {lfsr_bit, partial};
        end
    end

    assign word.word_valid = (level != '0);
    assign word.word_data  = mem[rd_ptr];
endmodule

// File: tb/tb_lfsr_packer.sv
// ----------------------------------------------------------------------------
// tb_lfsr_packer
// Bench for lfsr_packer (WIDTH=8, DEPTH=4). A behavioural stand-in for the
// lfsr block supplies rand_bit. The reference model treats the output as the
// LFSR bit stream cut into consecutive 8-bit chunks, tracks which chunks are
// queued from counts of requests, captures and pops, and is compared with the
// DUT on every falling edge.
// ----------------------------------------------------------------------------
module tb_lfsr_packer;
    localparam int W     = 8;
    localparam int D     = 4;
    localparam int LW    = $clog2(D + 1);
    localparam int NBITS = 4096;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic lfsr_en;
    logic lfsr_bit;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    lfsr_packer_if #(.WIDTH(W)) wif ();

    lfsr_packer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .lfsr_en  (lfsr_en),
        .lfsr_bit (lfsr_bit),
        .word     (wif),
        .level    (level)
    );

    // ---------------- bit stream ----------------
    logic bits [NBITS];

    function automatic void gen_bits();
        logic [15:0] seed;
        seed = 16'hECEB;
        for (int i = 0; i < 16; i++) bits[i] = seed[i];
        for (int i = 16; i < NBITS; i++)
            bits[i] = bits[i-16] ^ bits[i-14] ^ bits[i-13] ^ bits[i-11];
    endfunction

    function automatic logic [W-1:0] word_at(input int k);
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) w[i] = bits[(k * W + i) % NBITS];
        return w;
    endfunction

    // Stand-in for the lfsr block: registered rand_bit, one bit per en.
    int env_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_bit <= 1'b0;
            env_idx  <= 0;
        end else if (lfsr_en) begin
            lfsr_bit <= bits[env_idx % NBITS];
            env_idx  <= env_idx + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int n_cap, n_req, n_pop;
    logic pend;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        n_cap = 0; n_req = 0; n_pop = 0; pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_lfsr_en", lfsr_en, 0);
                check("rst_valid", wif.word_valid, 0);
                check("rst_data", wif.word_data, 0);
                check("rst_level", level, 0);
                exp_q.delete();
                got_q.delete();
                n_cap = 0; n_req = 0; n_pop = 0; pend = 1'b0;
            end else begin
                check("valid", wif.word_valid, exp_q.size() != 0);
                check("level", level, exp_q.size());
                if (exp_q.size() != 0) check("data", wif.word_data, exp_q[0]);
                // Outcome of the coming rising edge.
                if (wif.word_ready && exp_q.size() != 0) begin
                    got_q.push_back(wif.word_data);
                    void'(exp_q.pop_front());
                    n_pop++;
                end
                if (pend) begin
                    if (n_cap % W == W - 1) exp_q.push_back(word_at(n_cap / W));
                    n_cap++;
                end
                if (lfsr_en) begin
                    // A word may only be started if fewer than D words are held.
                    if (n_req % W == 0) check("credit", (n_req / W - n_pop) < D, 1);
                    n_req++;
                end
                pend = lfsr_en;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; run = 1'b0; wif.word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called right after run rises in cycle 0; returns the cycle of first valid.
    task automatic first_valid(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (wif.word_valid || cyc >= 60) break;
            cyc++;
        end
    endtask

    task automatic stream_until(input int nwords, input int budget);
        int cyc;
        cyc = 0;
        while (n_pop < nwords && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        check("stream_words", n_pop >= nwords, 1);
    endtask

    task automatic run_gaps(input int nwords);
        int cyc;
        cyc = 0;
        while (n_pop < nwords && cyc < 5000) begin
            int on_len;
            int off_len;
            on_len  = $urandom_range(1, 4);
            off_len = $urandom_range(0, 3);
            for (int i = 0; i < on_len; i++) begin
                @(posedge clk); #1;
                run = 1'b1;
                wif.word_ready = ($urandom_range(0, 3) != 0);
                cyc++;
            end
            for (int i = 0; i < off_len; i++) begin
                @(posedge clk); #1;
                run = 1'b0;
                wif.word_ready = ($urandom_range(0, 3) != 0);
                cyc++;
            end
        end
        check("gap_words", n_pop >= nwords, 1);
    endtask

    task automatic count_pulses(input int ncyc, output int pulses);
        pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (lfsr_en) pulses++;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int pulses;
        wif.word_ready = 1'b0;
        gen_bits();
        check("model_w0", word_at(0), 8'hEB);
        check("model_w1", word_at(1), 8'hEC);
        check("model_w2", word_at(2), 8'h2B);

        // Reset and idle.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_lfsr_en", lfsr_en, 0);
        check("idle_valid", wif.word_valid, 0);
        check("idle_data", wif.word_data, 0);
        check("idle_level", level, 0);

        // Basic stream.
        @(posedge clk); #1;
        run = 1'b1; wif.word_ready = 1'b1;
        first_valid(cyc);
        check("first_valid_cycle", cyc, 10);
        stream_until(40, 1000);
        check("got_size", got_q.size() >= 3, 1);
        if (got_q.size() >= 3) begin
            check("dut_w0", got_q[0], 8'hEB);
            check("dut_w1", got_q[1], 8'hEC);
            check("dut_w2", got_q[2], 8'h2B);
        end

        // Run gaps with random backpressure.
        do_reset();
        run_gaps(64);

        // Full FIFO.
        do_reset();
        @(posedge clk); #1;
        run = 1'b1;
        count_pulses(100, pulses);
        check("full_pulses", pulses, 32);
        check("full_lfsr_en", lfsr_en, 0);
        check("full_level", level, 4);
        check("full_head", wif.word_data, 8'hEB);
        @(posedge clk); #1 wif.word_ready = 1'b1;
        @(posedge clk); #1 wif.word_ready = 1'b0;
        count_pulses(60, pulses);
        check("refill_pulses", pulses, 8);
        check("refill_level", level, 4);
        check("refill_head", wif.word_data, 8'hEC);

        // Push and pop on the same edge with two words held.
        do_reset();
        @(posedge clk); #1;
        run = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("pp_level_before", level, 2);
        wif.word_ready = 1'b1;
        @(posedge clk); #1;
        wif.word_ready = 1'b0;
        check("pp_level_after", level, 2);
        check("pp_head", wif.word_data, 8'hEC);
        run = 1'b0; wif.word_ready = 1'b1;
        repeat (30) @(posedge clk);

        // Reset after 5 captured bits of the second word.
        do_reset();
        @(posedge clk); #1;
        run = 1'b1; wif.word_ready = 1'b1;
        repeat (14) @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_level", level, 0);
        check("mid_rst_valid", wif.word_valid, 0);
        check("mid_rst_data", wif.word_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; run = 1'b0; wif.word_ready = 1'b0;
        @(posedge clk); #1;
        run = 1'b1;
        first_valid(cyc);
        check("mid_first_valid_cycle", cyc, 10);
        check("mid_first_word", wif.word_data, 8'hEB);
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
